imem_debug_loader: RTL and testbench
====================================

// Module: imem_debug_loader
// PURPOSE
//  Sequencer for the instruction-RAM debug port (A2/WD2/WE2/RD2) on the IF-ID stage.
//  Takes a byte stream (e.g. from a UART receiver) and packs it little-endian into 32-bit words.
//  In PROGRAM mode it writes the words to consecutive word addresses.
//  In VERIFY mode it reads each word back and compares it against the stream.
//  Holds the CPU (cpu_hold -> pipeline en low) for the whole transfer.
// PARAMETERS
//  CNT_W   16  width of word_count and of the word counter
//  ERR_W   16  width of err_count; the counter saturates at all-ones
// PORTS
//  clk             in   1      system clock, all logic on posedge
//  rst             in   1      synchronous, active-high reset
//  start           in   1      1-cycle pulse; starts a transfer, accepted only in IDLE
//  verify          in   1      sampled with start: 0 = PROGRAM, 1 = VERIFY
//  base_addr       in   32     byte address of the first word; bits [1:0] forced to 0
//  word_count      in   CNT_W  number of words to transfer; sampled with start
//  abort           in   1      terminate the transfer; checked in every non-IDLE state
//  s_valid         in   1      stream byte valid
//  s_data          in   8      stream byte
//  s_ready         out  1      byte accepted when s_valid & s_ready
//  A2              out  32     debug-port address
//  WD2             out  32     debug-port write data
//  WE2             out  4      debug-port byte write enables
//  RD2             in   32     debug-port read data; valid 1 cycle after A2 is presented
//  cpu_hold        out  1      1 while busy; the top level gates pipeline en with it
//  busy            out  1      1 in any state other than IDLE
//  done            out  1      1-cycle pulse when the transfer completes normally
//  aborted         out  1      1-cycle pulse when the transfer ends by abort
//  err_count       out  ERR_W  VERIFY mismatches in the last transfer, saturating
//  first_err_addr  out  32     byte address of the first mismatch; 0 if there was none
// BEHAVIOUR
//  Reset values: state = IDLE; every output = 0, including counters and first_err_addr.
//  Reset in any state forces IDLE at that edge. WE2 is never 1 in the cycle after rst.
//  States: IDLE, COLLECT, WRITE, RD_ADDR, RD_CMP, DONE.
//  IDLE
//   - On start: latch addr = {base_addr[31:2],2'b00}, cnt_tgt = word_count and the mode.
//   - Clear err_count, first_err_addr, byte_idx and cnt.
//   - Next state is COLLECT, or DONE if word_count == 0.
//  COLLECT
//   - s_ready = 1.
//   - Each accepted byte goes to word[8*byte_idx +: 8], then byte_idx++.
//   - On the 4th byte: go to WRITE (PROGRAM) or RD_ADDR (VERIFY).
//   - s_valid low leaves the state unchanged; there is no timeout.
//  WRITE (1 cycle)
//   - Drive A2 = addr, WD2 = word, WE2 = 4'hF.
//   - Then addr += 4 and cnt++.
//   - Next state is DONE if cnt+1 == cnt_tgt, otherwise COLLECT.
//  RD_ADDR (1 cycle)
//   - Drive A2 = addr with WE2 = 0.
//   - Next state is RD_CMP.
//  RD_CMP (1 cycle)
//   - Keep A2 = addr.
//   - If RD2 != word: err_count++ (saturating); if it was 0, also capture first_err_addr = addr.
//   - Advance addr and cnt, and pick the next state, as in WRITE.
//  DONE
//   - done = 1 for one cycle, then IDLE.
//  s_ready is 0 outside COLLECT, so at most one byte is accepted per cycle.
//  WE2 is 4'hF only in WRITE and 0 in every other state.
//  When not driven, A2 and WD2 hold their last value.
//  Latency:
//   - PROGRAM: 5 cycles per word at full stream rate (4 COLLECT + 1 WRITE).
//   - VERIFY: 6 cycles per word.
//  abort (checked in any non-IDLE state)
//   - Takes priority over every transition.
//   - If the current state is WRITE, the write in that cycle completes.
//   - Next state is IDLE, and aborted pulses in that first IDLE cycle.
//   - A partial word is discarded.
//   - done does not pulse; err_count and first_err_addr are held.
//  start while busy is ignored.
//  addr wraps modulo 2^32.
//  cnt compares at CNT_W bits, so word_count = 2^CNT_W - 1 is the maximum transfer.
// TESTING
//  1. PROGRAM, base 0x100, count 2, bytes 11 22 33 44 55 66 77 88:
//     -> WE2 = F at A2 = 0x100 with WD2 = 0x44332211, then at 0x104 with WD2 = 0x88776655;
//     -> done pulses once.
//  2. VERIFY of the test-1 image, where RAM word 0x104 = 0x88776656:
//     -> err_count = 1, first_err_addr = 0x104, WE2 never asserted.
//  3. word_count = 0:
//     -> start, then done on the next cycle; s_ready stays 0; no write.
//  4. abort after 2 bytes of word 1 (count 3):
//     -> aborted pulses, no done, exactly 1 write seen, busy = 0.
//  5. s_valid toggling every other cycle:
//     -> correct word packing; start pulses while busy are ignored.
//  6. rst asserted mid-COLLECT:
//     -> all outputs 0 on the next cycle; a following transfer behaves like test 1.

Source files
------------

// File: rtl/imem_debug_loader.sv
// -----------------------------------------------------------------------------
// imem_debug_loader
//
// Purpose:
//   Drives the instruction-RAM debug port (A2/WD2/WE2/RD2) from a byte stream,
//   for example a UART receiver. Bytes are packed little-endian into 32-bit
//   words. In PROGRAM mode each word is written to consecutive word addresses.
//   In VERIFY mode each word is read back and compared against the stream, and
//   mismatches are counted. The CPU pipeline is held for the whole transfer.
//
// Ports:
//   clk            - system clock, all logic on the rising edge
//   rst            - synchronous active-high reset
//   start          - one-cycle pulse starting a transfer (accepted in IDLE only)
//   verify         - sampled with start: 0 = PROGRAM, 1 = VERIFY
//   base_addr      - byte address of the first word (low two bits ignored)
//   word_count     - number of words to transfer, sampled with start
//   abort          - terminates a transfer in progress
//   s_valid/s_data - incoming stream byte
//   s_ready        - stream byte accepted when s_valid & s_ready
//   A2/WD2/WE2     - debug-port address, write data and byte write enables
//   RD2            - debug-port read data, valid one cycle after A2
//   cpu_hold       - holds the CPU pipeline while a transfer is in progress
//   busy           - high in any state other than IDLE
//   done           - one-cycle pulse on normal completion
//   aborted        - one-cycle pulse when a transfer ends by abort
//   err_count      - saturating count of VERIFY mismatches in the last transfer
//   first_err_addr - byte address of the first mismatch, 0 if none
// -----------------------------------------------------------------------------
module imem_debug_loader #(
  parameter int CNT_W = 16,
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             verify,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] word_count,
  input  logic             abort,
  input  logic             s_valid,
  input  logic [7:0]       s_data,
  output logic             s_ready,
  output logic [31:0]      A2,
  output logic [31:0]      WD2,
  output logic [3:0]       WE2,
  input  logic [31:0]      RD2,
  output logic             cpu_hold,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [ERR_W-1:0] err_count,
  output logic [31:0]      first_err_addr
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_WRITE   = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_CMP  = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_tgt_q, cnt_tgt_d;
  logic             mode_q, mode_d;
  logic [31:0]      word_q, word_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [31:0]      first_err_q, first_err_d;
  logic             aborted_q, aborted_d;
  logic [31:0]      a2_q;
  logic [31:0]      wd2_q;

  logic [CNT_W-1:0] cnt_inc;
  logic             last_word;

  // The two low address bits are forced to zero, so they never reach the logic.
  logic             unused_base_lsbs;
  assign unused_base_lsbs = ^base_addr[1:0];

  // The counter is compared at CNT_W bits, so an all-ones word_count is the
  // largest transfer and the increment wraps rather than widening.
  assign cnt_inc   = cnt_q + 1'b1;
  assign last_word = (cnt_inc == cnt_tgt_q);

  // Next-state and output decode. A2/WD2 fall back to the hold registers in
  // states that do not drive the port, so the port keeps its last value.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    cnt_tgt_d   = cnt_tgt_q;
    mode_d      = mode_q;
    word_d      = word_q;
    byte_idx_d  = byte_idx_q;
    err_d       = err_q;
    first_err_d = first_err_q;
    aborted_d   = 1'b0;
    s_ready     = 1'b0;
    WE2         = 4'h0;
    A2          = a2_q;
    WD2         = wd2_q;
    done        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d      = {base_addr[31:2], 2'b00};
          cnt_tgt_d   = word_count;
          mode_d      = verify;
          err_d       = '0;
          first_err_d = '0;
          byte_idx_d  = 2'd0;
          cnt_d       = '0;
          state_d     = (word_count == '0) ? ST_DONE : ST_COLLECT;
        end
      end

      ST_COLLECT: begin
        s_ready = 1'b1;
        if (s_valid) begin
          word_d[8*byte_idx_q +: 8] = s_data;
          byte_idx_d                = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            state_d = mode_q ? ST_RD_ADDR : ST_WRITE;
          end
        end
      end

      ST_WRITE: begin
        WE2     = 4'hF;
        A2      = addr_q;
        WD2     = word_q;
        addr_d  = addr_q + 32'd4;
        cnt_d   = cnt_inc;
        state_d = last_word ? ST_DONE : ST_COLLECT;
      end

      ST_RD_ADDR: begin
        A2      = addr_q;
        state_d = ST_RD_CMP;
      end

      ST_RD_CMP: begin
        // RD2 now reflects the address presented in RD_ADDR.
        A2 = addr_q;
        if (RD2 != word_q) begin
          if (err_q != '1) begin
            err_d = err_q + 1'b1;
          end
          if (err_q == '0) begin
            first_err_d = addr_q;
          end
        end
        addr_d  = addr_q + 32'd4;
        cnt_d   = cnt_inc;
        state_d = last_word ? ST_DONE : ST_COLLECT;
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort overrides every transition. A write already on the port this
    // cycle still happens; the partial word and any error update are dropped.
    if (state_q != ST_IDLE && abort) begin
      state_d     = ST_IDLE;
      aborted_d   = 1'b1;
      done        = 1'b0;
      byte_idx_d  = 2'd0;
      err_d       = err_q;
      first_err_d = first_err_q;
    end
  end

  // State and datapath registers. The A2/WD2 hold registers track whatever
  // the port showed this cycle so idle states repeat it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      cnt_tgt_q   <= '0;
      mode_q      <= 1'b0;
      word_q      <= '0;
      byte_idx_q  <= 2'd0;
      err_q       <= '0;
      first_err_q <= '0;
      aborted_q   <= 1'b0;
      a2_q        <= '0;
      wd2_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      cnt_tgt_q   <= cnt_tgt_d;
      mode_q      <= mode_d;
      word_q      <= word_d;
      byte_idx_q  <= byte_idx_d;
      err_q       <= err_d;
      first_err_q <= first_err_d;
      aborted_q   <= aborted_d;
      a2_q        <= A2;
      wd2_q       <= WD2;
    end
  end

  assign busy           = (state_q != ST_IDLE);
  assign cpu_hold       = busy;
  assign aborted        = aborted_q;
  assign err_count      = err_q;
  assign first_err_addr = first_err_q;

endmodule

// File: tb/tb_imem_debug_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_debug_loader
//
// Directed bench for imem_debug_loader. A small RAM model answers the debug
// port with one cycle of read latency, and a monitor logs every write and
// every done/aborted pulse so each scenario can check what it caused.
// -----------------------------------------------------------------------------
module tb_imem_debug_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic        verify;
  logic [31:0] baseAddr;
  logic [15:0] wordCount;
  logic        abort;
  logic        sValid;
  logic [7:0]  sData;
  logic        sReady;
  logic [31:0] a2;
  logic [31:0] wd2;
  logic [3:0]  we2;
  logic [31:0] rd2;
  logic        cpuHold;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [15:0] errCount;
  logic [31:0] firstErrAddr;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [0:63];
  logic        corruptEn = 1'b0;

  int          writesSeen  = 0;
  int          doneSeen    = 0;
  int          abortedSeen = 0;
  logic [31:0] wrAddrQ [$];
  logic [31:0] wrDataQ [$];
  logic [3:0]  wrWeQ   [$];

  imem_debug_loader #(.CNT_W(16), .ERR_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .verify         (verify),
    .base_addr      (baseAddr),
    .word_count     (wordCount),
    .abort          (abort),
    .s_valid        (sValid),
    .s_data         (sData),
    .s_ready        (sReady),
    .A2             (a2),
    .WD2            (wd2),
    .WE2            (we2),
    .RD2            (rd2),
    .cpu_hold       (cpuHold),
    .busy           (busy),
    .done           (done),
    .aborted        (aborted),
    .err_count      (errCount),
    .first_err_addr (firstErrAddr)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: writes on WE2, registered read of A2. corruptEn flips the two
  // low bits of word index 1 so 0x88776655 reads back as 0x88776656.
  always @(posedge clk) begin
    if (we2 == 4'hF) mem[a2[7:2]] <= wd2;
    rd2 <= mem[a2[7:2]] ^ ((corruptEn && a2[7:2] == 6'd1) ? 32'h3 : 32'h0);
  end

  // Monitor on the falling edge, well away from the active edge.
  always @(negedge clk) begin
    if (we2 != 4'h0) begin
      wrAddrQ.push_back(a2);
      wrDataQ.push_back(wd2);
      wrWeQ.push_back(we2);
      writesSeen++;
    end
    if (done === 1'b1) doneSeen++;
    if (aborted === 1'b1) abortedSeen++;
  end

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Start pulse for one cycle.
  task automatic applyStart(input logic v, input logic [31:0] b, input logic [15:0] n);
    start     = 1'b1;
    verify    = v;
    baseAddr  = b;
    wordCount = n;
    cyc();
    start = 1'b0;
  endtask

  // Offer one byte until it is accepted, with a bounded wait.
  task automatic applyByte(input logic [7:0] b);
    bit ok = 1'b0;
    sValid = 1'b1;
    sData  = b;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (sReady === 1'b1) begin
        cyc();
        ok = 1'b1;
        break;
      end
      cyc();
    end
    sValid = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL byte_accept: byte %h not accepted, expected acceptance within 50 cycles", b);
    end
  endtask

  // Wait for done or aborted, bounded.
  task automatic waitEnd(input int d0, input int a0);
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (doneSeen > d0 || abortedSeen > a0) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL end_timeout: no done/aborted, expected one within 50 cycles");
    end
  endtask

  // Hold reset for several cycles and confirm every output is cleared.
  task automatic test_reset();
    rst = 1'b1;
    cyc(); cyc(); cyc();
    #1;
    checks++;
    if ({busy, cpuHold, sReady, done, aborted, we2} !== 9'd0) begin
      failures++;
      $display("[TB] FAIL reset_ctrl: got %b expected 0", {busy, cpuHold, sReady, done, aborted, we2});
    end
    checks++;
    if ({a2, wd2} !== 64'd0) begin
      failures++;
      $display("[TB] FAIL reset_port: A2=%h WD2=%h expected 0", a2, wd2);
    end
    checks++;
    if (errCount !== 16'd0 || firstErrAddr !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_err: err=%0d first=%h expected 0", errCount, firstErrAddr);
    end
    rst = 1'b0;
    cyc();
  endtask

  // PROGRAM two words at base; bytes 11..88 pack to 0x44332211, 0x88776655.
  task automatic test_program(input logic [31:0] base, input string tag);
    int w0 = writesSeen;
    int d0 = doneSeen;
    int a0 = abortedSeen;
    logic [7:0] bytes [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    applyStart(1'b0, base, 16'd2);
    for (int i = 0; i < 8; i++) applyByte(bytes[i]);
    waitEnd(d0, a0);
    #1;
    checks++;
    if (writesSeen - w0 !== 2) begin
      failures++;
      $display("[TB] FAIL %s_write_count: got %0d expected 2", tag, writesSeen - w0);
    end else begin
      checks++;
      if (wrAddrQ[w0] !== base || wrDataQ[w0] !== 32'h44332211 || wrWeQ[w0] !== 4'hF) begin
        failures++;
        $display("[TB] FAIL %s_write0: got A2=%h WD2=%h WE2=%h expected %h 44332211 f", tag, wrAddrQ[w0], wrDataQ[w0], wrWeQ[w0], base);
      end
      checks++;
      if (wrAddrQ[w0+1] !== base + 32'd4 || wrDataQ[w0+1] !== 32'h88776655 || wrWeQ[w0+1] !== 4'hF) begin
        failures++;
        $display("[TB] FAIL %s_write1: got A2=%h WD2=%h WE2=%h expected %h 88776655 f", tag, wrAddrQ[w0+1], wrDataQ[w0+1], wrWeQ[w0+1], base + 32'd4);
      end
    end
    checks++;
    if (doneSeen - d0 !== 1 || abortedSeen - a0 !== 0) begin
      failures++;
      $display("[TB] FAIL %s_done: got done=%0d aborted=%0d expected 1 0", tag, doneSeen - d0, abortedSeen - a0);
    end
    checks++;
    if (busy !== 1'b0 || a2 !== base + 32'd4 || wd2 !== 32'h88776655) begin
      failures++;
      $display("[TB] FAIL %s_hold: got busy=%b A2=%h WD2=%h expected 0 %h 88776655", tag, busy, a2, wd2, base + 32'd4);
    end
  endtask

  // VERIFY the programmed image against a RAM whose word 0x104 is corrupted.
  task automatic test_verify();
    int w0 = writesSeen;
    int d0 = doneSeen;
    int a0 = abortedSeen;
    logic [7:0] bytes [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    corruptEn = 1'b1;
    applyStart(1'b1, 32'h0000_0100, 16'd2);
    for (int i = 0; i < 8; i++) applyByte(bytes[i]);
    waitEnd(d0, a0);
    #1;
    corruptEn = 1'b0;
    checks++;
    if (errCount !== 16'd1) begin
      failures++;
      $display("[TB] FAIL verify_err_count: got %0d expected 1", errCount);
    end
    checks++;
    if (firstErrAddr !== 32'h0000_0104) begin
      failures++;
      $display("[TB] FAIL verify_first_err: got %h expected 00000104", firstErrAddr);
    end
    checks++;
    if (writesSeen - w0 !== 0 || doneSeen - d0 !== 1) begin
      failures++;
      $display("[TB] FAIL verify_no_write: got writes=%0d done=%0d expected 0 1", writesSeen - w0, doneSeen - d0);
    end
  endtask

  // Reset in the middle of COLLECT, then an ordinary transfer.
  task automatic test_reset_mid();
    applyStart(1'b0, 32'h0000_0400, 16'd2);
    applyByte(8'hDE);
    applyByte(8'hAD);
    rst = 1'b1;
    cyc();
    #1;
    checks++;
    if ({busy, cpuHold, sReady, done, aborted, we2} !== 9'd0 || a2 !== 32'd0 || wd2 !== 32'd0) begin
      failures++;
      $display("[TB] FAIL rst_mid_outputs: got ctrl=%b A2=%h WD2=%h expected all 0", {busy, cpuHold, sReady, done, aborted, we2}, a2, wd2);
    end
    checks++;
    if (errCount !== 16'd0 || firstErrAddr !== 32'd0) begin
      failures++;
      $display("[TB] FAIL rst_mid_err: got err=%0d first=%h expected 0", errCount, firstErrAddr);
    end
    rst = 1'b0;
    cyc();
    test_program(32'h0000_0100, "after_rst");
  endtask

  // word_count = 0 goes straight to DONE with no stream traffic.
  task automatic test_zero_count();
    int w0 = writesSeen;
    sValid = 1'b1;
    sData  = 8'h5A;
    applyStart(1'b0, 32'h0000_0500, 16'd0);
    #1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || sReady !== 1'b0) begin
      failures++;
      $display("[TB] FAIL zero_done: got done=%b busy=%b s_ready=%b expected 1 1 0", done, busy, sReady);
    end
    cyc();
    #1;
    sValid = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || sReady !== 1'b0) begin
      failures++;
      $display("[TB] FAIL zero_idle: got done=%b busy=%b s_ready=%b expected 0 0 0", done, busy, sReady);
    end
    checks++;
    if (writesSeen - w0 !== 0) begin
      failures++;
      $display("[TB] FAIL zero_no_write: got %0d expected 0", writesSeen - w0);
    end
  endtask

  // Abort after two bytes of the second word of a three-word program.
  task automatic test_abort();
    int w0 = writesSeen;
    int d0 = doneSeen;
    int a0 = abortedSeen;
    applyStart(1'b0, 32'h0000_0200, 16'd3);
    for (int i = 1; i <= 6; i++) applyByte(8'(i));
    abort = 1'b1;
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL abort_pre: got done=%b busy=%b expected 0 1", done, busy);
    end
    cyc();
    abort = 1'b0;
    #1;
    checks++;
    if (aborted !== 1'b1 || busy !== 1'b0 || cpuHold !== 1'b0) begin
      failures++;
      $display("[TB] FAIL abort_pulse: got aborted=%b busy=%b hold=%b expected 1 0 0", aborted, busy, cpuHold);
    end
    cyc();
    #1;
    checks++;
    if (aborted !== 1'b0) begin
      failures++;
      $display("[TB] FAIL abort_once: got aborted=%b expected 0", aborted);
    end
    checks++;
    if (writesSeen - w0 !== 1 || doneSeen - d0 !== 0 || abortedSeen - a0 !== 1) begin
      failures++;
      $display("[TB] FAIL abort_counts: got writes=%0d done=%0d aborted=%0d expected 1 0 1", writesSeen - w0, doneSeen - d0, abortedSeen - a0);
    end else begin
      checks++;
      if (wrAddrQ[w0] !== 32'h0000_0200 || wrDataQ[w0] !== 32'h04030201) begin
        failures++;
        $display("[TB] FAIL abort_write: got A2=%h WD2=%h expected 00000200 04030201", wrAddrQ[w0], wrDataQ[w0]);
      end
    end
  endtask

  // s_valid every other cycle, with stray start pulses while busy.
  task automatic test_back_to_back();
    int w0 = writesSeen;
    int d0 = doneSeen;
    int a0 = abortedSeen;
    applyStart(1'b0, 32'h0000_0300, 16'd2);
    for (int i = 0; i < 8; i++) begin
      applyByte(8'hA1 + 8'(i));
      if (i == 2 || i == 5) begin
        start     = 1'b1;
        verify    = 1'b1;
        baseAddr  = 32'h0000_0000;
        wordCount = 16'd5;
      end
      cyc();
      start = 1'b0;
    end
    waitEnd(d0, a0);
    #1;
    checks++;
    if (writesSeen - w0 !== 2 || doneSeen - d0 !== 1) begin
      failures++;
      $display("[TB] FAIL toggle_counts: got writes=%0d done=%0d expected 2 1", writesSeen - w0, doneSeen - d0);
    end else begin
      checks++;
      if (wrAddrQ[w0] !== 32'h0000_0300 || wrDataQ[w0] !== 32'hA4A3A2A1) begin
        failures++;
        $display("[TB] FAIL toggle_word0: got A2=%h WD2=%h expected 00000300 a4a3a2a1", wrAddrQ[w0], wrDataQ[w0]);
      end
      checks++;
      if (wrAddrQ[w0+1] !== 32'h0000_0304 || wrDataQ[w0+1] !== 32'hA8A7A6A5) begin
        failures++;
        $display("[TB] FAIL toggle_word1: got A2=%h WD2=%h expected 00000304 a8a7a6a5", wrAddrQ[w0+1], wrDataQ[w0+1]);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL toggle_idle: got busy=%b expected 0", busy);
    end
  endtask

  // Scenario sequence.
  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    verify    = 1'b0;
    baseAddr  = 32'd0;
    wordCount = 16'd0;
    abort     = 1'b0;
    sValid    = 1'b0;
    sData     = 8'd0;
    test_reset();
    test_program(32'h0000_0100, "program");
    test_verify();
    test_reset_mid();
    test_zero_count();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
